instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Front-end stage directly upstream of the CPU controller.
- Owns the PC and drives a request/valid handshake to instruction memory.
- Holds the fetched instruction and presents opcode/immediate to the controller and datapath.
- When the back end accepts, applies the controller's branch/jump/zero decision to choose the next PC.

Parameters:
- AW, 8, PC/instruction address width; PC wraps modulo 2^AW.
- IW, 8, instruction width; op = instr[IW-1:IW-3], imm = instr[3:0], jtarget = instr[IW-4:0] zero-extended to AW.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held high until imem_valid.
- imem_addr  output  AW  fetch address (= pc); stable while imem_req high.
- imem_rdata  input  IW  instruction word; sampled when imem_req & imem_valid.
- imem_valid  input  1  memory data valid; ignored unless imem_req high.
- instr_valid  output  1  held instruction is valid for the back end.
- op  output  3  opcode to controller, = ir[IW-1:IW-3].
- imm  output  4  immediate field, = ir[3:0].
- pc  output  AW  address of the held instruction.
- exec_ready  input  1  back end consumes the held instruction this cycle.
- branch  input  1  controller branch decode for the held instruction.
- zero  input  1  ALU zero flag for the held instruction.
- jump  input  1  controller jump decode for the held instruction.
- retired  output  8  count of consumed instructions; wraps 255 -> 0.

Behaviour:
- States: FETCH, ISSUE (plus HALT when the optional feature is enabled).
- Reset (synchronous, takes effect at the edge where reset=1):
  - state=FETCH, pc=RESET_PC, ir=0, retired=0.
  - instr_valid=0, imem_req=0; imem_req rises the cycle after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On an edge with imem_valid=1: ir<=imem_rdata, go to ISSUE, imem_req=0 next cycle.
  - Memory latency is unbounded; zero-wait memory (valid in the first request cycle) gives 2 cycles per instruction minimum.
- ISSUE:
  - instr_valid=1, imem_req=0; op/imm/pc stable until consumed.
  - While exec_ready=0, stay in ISSUE; branch/zero/jump are ignored.
  - On an edge with exec_ready=1:
    - retired<=retired+1.
    - Next-PC priority: jump -> jtarget; else branch & zero -> pc+1+sext(imm) mod 2^AW; else pc+1 mod 2^AW.
    - Go to FETCH.
- Simultaneous jump=1 and branch&zero=1: jump wins.
- Branch with zero=0 falls through to pc+1.
- imem_valid asserted while in ISSUE or while imem_req=0: ignored, no state change.
- PC wrap: pc=2^AW-1 with fall-through gives pc=0; a negative offset below 0 wraps upward.
- Reset mid-fetch (imem_req high): the outstanding request is abandoned, imem_req drops next cycle, and any late imem_valid is ignored.
- Reset in ISSUE: instruction discarded, not counted in retired.

Optional Feature:
- Macro: INSTR_FETCH_HALT_EN.
- Enabled:
  - Consuming an instruction with op=3'b111 and imm=4'hF increments retired and enters HALT instead of FETCH.
  - In HALT: imem_req=0, instr_valid=0, pc frozen at the halt instruction's address.
  - Output halted=1 (extra 1-bit port, present only with the macro).
  - Only reset leaves HALT.
- Disabled:
  - No HALT state and no halted port.
  - op=3'b111/imm=4'hF is an ordinary instruction; next PC follows the normal rules.

Test Plan:
- Reset then zero-wait memory returning 8'h21 at addr 0, exec_ready=1 permanently -> imem_req=1 with addr 0 in cycle 1; instr_valid=1, op=3'b001, imm=4'h1 in cycle 2; next request at addr 1; retired=1.
- Memory with 3 wait cycles at pc=5 -> imem_req and imem_addr=5 held stable for 4 cycles; no instr_valid until the cycle after imem_valid.
- pc=10, branch=1, zero=1, imm=4'hE (-2), exec_ready=1 -> next imem_addr=9; same case with zero=0 -> next imem_addr=11.
- jump=1 and branch=1, zero=1, instr=8'h1F -> next imem_addr=8'h1F (jump priority); exec_ready=0 for 4 cycles beforehand -> op/pc unchanged and retired unchanged.
- pc=8'hFF fall-through -> next imem_addr=0; reset asserted during a pending request -> imem_req=0 the next cycle, a late imem_valid is ignored, and the fetch restarts at RESET_PC.
- INSTR_FETCH_HALT_EN defined, instr 8'hEF consumed at pc=3 -> halted=1, imem_req stays 0 for 20 cycles, pc=3, retired incremented once; reset clears halted.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus: request/valid handshake between fetch stage and memory.
interface instr_fetch_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned IW = 8
);
  logic          req;
  logic [AW-1:0] addr;
  logic [IW-1:0] rdata;
  logic          valid;

  modport master (output req, output addr, input rdata, input valid);
  modport slave  (input req, input addr, output rdata, output valid);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over the imem bus, holds the instruction
// for the back end and picks the next PC. Define INSTR_FETCH_HALT_EN to add the HALT state.
module instr_fetch #(
  parameter int unsigned    AW       = 8,
  parameter int unsigned    IW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_if.master     imem,
  output logic              instr_valid,
  output logic [2:0]        op,
  output logic [3:0]        imm,
  output logic [AW-1:0]     pc,
  input  logic              exec_ready,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
`ifdef INSTR_FETCH_HALT_EN
  output logic              halted,
`endif
  output logic [7:0]        retired
);

`ifdef INSTR_FETCH_HALT_EN
  typedef enum logic [1:0] {StFetch, StIssue, StHalt} state_e;
`else
  typedef enum logic [0:0] {StFetch, StIssue} state_e;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [7:0]    retired_q, retired_d;
  logic          armed_q;
  logic [AW-1:0] jtarget, br_target, seq_pc, next_pc;

  // Cleared by reset so the first request only goes out the cycle after reset drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      armed_q   <= 1'b1;
    end
  end

  always_comb begin
    jtarget   = AW'(ir_q[IW-4:0]);
    seq_pc    = pc_q + AW'(1);
    br_target = seq_pc + {{(AW-4){ir_q[3]}}, ir_q[3:0]};
    if (jump) begin
      next_pc = jtarget;
    end else if (branch && zero) begin
      next_pc = br_target;
    end else begin
      next_pc = seq_pc;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    retired_d   = retired_q;
    imem.req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      StFetch: begin
        imem.req = armed_q;
        if (armed_q && imem.valid) begin
          ir_d    = imem.rdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        if (exec_ready) begin
          retired_d = retired_q + 8'd1;
          state_d   = StFetch;
          pc_d      = next_pc;
`ifdef INSTR_FETCH_HALT_EN
          if (ir_q[IW-1:IW-3] == 3'b111 && ir_q[3:0] == 4'hF) begin
            state_d = StHalt;
            pc_d    = pc_q;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  assign imem.addr = pc_q;
  assign op        = ir_q[IW-1:IW-3];
  assign imm       = ir_q[3:0];
  assign pc        = pc_q;
  assign retired   = retired_q;
`ifdef INSTR_FETCH_HALT_EN
  assign halted    = (state_q == StHalt);
`endif

endmodule
